alu_result_stage: RTL and testbench

// - Registered stage directly downstream of the 64-bit combinational ALU.
// - Captures ALU result, carry, opcode and operands; derives status flags Z/N/C/V/DZ.
// - Buffers results in a 2-entry skid buffer with valid/ready on both sides, so the
//   ALU output is decoupled from writeback back-pressure.
// - Keeps a retire counter and a sticky divide-by-zero indicator.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_result_stage_if.sv | 11 +
 rtl/alu_skid_buffer.sv | 59 +++++
 rtl/alu_result_stage.sv | 107 ++++++++++
 tb/tb_alu_result_stage.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, status-flag bit positions and default widths.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;
  localparam int unsigned DEFAULT_OPW   = 4;
  localparam int unsigned DEFAULT_CNTW  = 32;
  localparam int unsigned FLAGW         = 5;

  localparam logic [DEFAULT_OPW-1:0] OP_ADD   = 4'b0000;
  localparam logic [DEFAULT_OPW-1:0] OP_SUB   = 4'b0001;
  localparam logic [DEFAULT_OPW-1:0] OP_MUL   = 4'b0010;
  localparam logic [DEFAULT_OPW-1:0] OP_DIV   = 4'b0011;
  localparam logic [DEFAULT_OPW-1:0] OP_PASSB = 4'b0111;
  localparam logic [DEFAULT_OPW-1:0] OP_AND   = 4'b1000;
  localparam logic [DEFAULT_OPW-1:0] OP_OR    = 4'b1001;
  localparam logic [DEFAULT_OPW-1:0] OP_XOR   = 4'b1010;
  localparam logic [DEFAULT_OPW-1:0] OP_NOR   = 4'b1100;

  localparam int unsigned FLAG_Z  = 0;
  localparam int unsigned FLAG_N  = 1;
  localparam int unsigned FLAG_C  = 2;
  localparam int unsigned FLAG_V  = 3;
  localparam int unsigned FLAG_DZ = 4;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] result;
    logic [FLAGW-1:0]         flags;
  } entry_t;

  // Undefined opcodes execute as ADD in the ALU, so they flag as ADD here too.
  function automatic logic op_is_add(input logic [DEFAULT_OPW-1:0] op);
    logic add;
    add = 1'b1;
    case (op)
      OP_SUB, OP_MUL, OP_DIV, OP_PASSB, OP_AND, OP_OR, OP_XOR, OP_NOR: add = 1'b0;
      default: add = 1'b1;
    endcase
    return add;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Generic valid/ready channel carrying a flat payload.
interface alu_result_stage_if #(
  parameter int unsigned DW = 69
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/alu_skid_buffer.sv
// Two-entry FIFO-ordered valid/ready buffer with registered ready and head data.
module alu_skid_buffer #(
  parameter int unsigned DW = 69
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   up,
  alu_result_stage_if.master  dn
);

  logic [1:0]    count_q, count_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] tail_q, tail_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          push_c, pop_c;

  assign push_c   = up.valid & in_ready_q;
  assign pop_c    = out_valid_q & dn.ready;
  assign up.ready = in_ready_q;
  assign dn.valid = out_valid_q;
  assign dn.data  = head_q;

  // A push lands in the head slot whenever the head is (or becomes) free.
  always_comb begin
    count_d = count_q + 2'(push_c) - 2'(pop_c);
    head_d  = head_q;
    tail_d  = tail_q;
    if (pop_c) begin
      head_d = tail_q;
    end
    if (push_c) begin
      if (count_q == 2'd0 || (count_q == 2'd1 && pop_c)) begin
        head_d = up.data;
      end else begin
        tail_d = up.data;
      end
    end
    in_ready_d  = (count_d != 2'd2);
    out_valid_d = (count_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered stage after the ALU: derives status flags, buffers results two deep,
// counts retired entries and tracks a sticky divide-by-zero indication.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned OPW   = DEFAULT_OPW,
  parameter int unsigned CNTW  = DEFAULT_CNTW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [FLAGW-1:0] out_flags,
  output logic [CNTW-1:0]  retire_count,
  output logic             div0_sticky,
  input  logic             clr_sticky
);

  localparam int unsigned PW  = WIDTH + FLAGW;
  localparam int unsigned MSB = WIDTH - 1;

  logic             is_add_c, is_sub_c, is_div_c, dz_c;
  logic [WIDTH-1:0] result_c;
  logic [FLAGW-1:0] flags_c;
  logic             push_c, pop_c;
  logic [CNTW-1:0]  retire_count_q, retire_count_d;
  logic             div0_sticky_q, div0_sticky_d;

  alu_result_stage_if #(.DW(PW)) up_ch ();
  alu_result_stage_if #(.DW(PW)) dn_ch ();

  // Flags are evaluated on the raw ALU outputs and stored with the entry.
  always_comb begin
    is_add_c = op_is_add(in_op);
    is_sub_c = (in_op == OP_SUB);
    is_div_c = (in_op == OP_DIV);
    dz_c     = is_div_c && (in_b == '0);
    result_c = dz_c ? '1 : in_result;
    flags_c  = '0;
    flags_c[FLAG_DZ] = dz_c;
    flags_c[FLAG_Z]  = (result_c == '0);
    flags_c[FLAG_N]  = result_c[MSB];
    if (is_add_c) begin
      flags_c[FLAG_C] = in_carry;
      flags_c[FLAG_V] = (in_a[MSB] == in_b[MSB]) && (in_result[MSB] != in_a[MSB]);
    end else if (is_sub_c) begin
      flags_c[FLAG_C] = (in_a < in_b);
      flags_c[FLAG_V] = (in_a[MSB] != in_b[MSB]) && (in_result[MSB] != in_a[MSB]);
    end
  end

  assign up_ch.valid = in_valid;
  assign up_ch.data  = {result_c, flags_c};
  assign in_ready    = up_ch.ready;
  assign dn_ch.ready = out_ready;
  assign out_valid   = dn_ch.valid;
  assign out_result  = dn_ch.data[PW-1:FLAGW];
  assign out_flags   = dn_ch.data[FLAGW-1:0];

  alu_skid_buffer #(.DW(PW)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .up    (up_ch.slave),
    .dn    (dn_ch.master)
  );

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  // Saturating retire counter; a DZ push beats a same-cycle clear.
  always_comb begin
    retire_count_d = retire_count_q;
    if (pop_c && (retire_count_q != '1)) begin
      retire_count_d = retire_count_q + CNTW'(1);
    end
    div0_sticky_d = div0_sticky_q;
    if (clr_sticky) begin
      div0_sticky_d = 1'b0;
    end
    if (push_c && dz_c) begin
      div0_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_count_q <= '0;
      div0_sticky_q  <= 1'b0;
    end else begin
      retire_count_q <= retire_count_d;
      div0_sticky_q  <= div0_sticky_d;
    end
  end

  assign retire_count = retire_count_q;
  assign div0_sticky  = div0_sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed flags.
module tb_alu_result_stage;

  localparam int unsigned W = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    in_op;
  logic [W-1:0]  in_a, in_b;
  logic          in_carry;
  logic          clr_sticky;
  logic [4:0]    out_flags;
  logic [31:0]   retire_count;
  logic          div0_sticky;

  alu_result_stage_if #(.DW(W)) in_ch ();
  alu_result_stage_if #(.DW(W)) out_ch ();

  alu_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_ch.valid),
    .in_ready     (in_ch.ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_result    (in_ch.data),
    .in_carry     (in_carry),
    .out_valid    (out_ch.valid),
    .out_ready    (out_ch.ready),
    .out_result   (out_ch.data),
    .out_flags    (out_flags),
    .retire_count (retire_count),
    .div0_sticky  (div0_sticky),
    .clr_sticky   (clr_sticky)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: entry = {result[63:0], dz, v, c, n, z}
  function automatic logic [68:0] model_entry(input logic [3:0] op, input logic [63:0] a,
                                               input logic [63:0] b, input logic [63:0] r,
                                               input logic cy);
    logic dz, v, c;
    logic [63:0] res;
    dz = 1'b0; v = 1'b0; c = 1'b0; res = r;
    case (op)
      4'h1: begin
        c = (a < b);
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      4'h3: if (b == 64'd0) begin dz = 1'b1; res = {64{1'b1}}; end
      4'h2, 4'h7, 4'h8, 4'h9, 4'hA, 4'hC: ;
      default: begin
        c = cy;
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
    endcase
    return {res, dz, v, c, res[63], (res == 64'd0)};
  endfunction

  logic [68:0] mq[$];
  logic [31:0] m_retire;
  logic        m_sticky;
  logic        live = 1'b0;

  // Model advances on each rising edge from the inputs and its own occupancy.
  always @(posedge clk) begin
    logic m_push, m_pop;
    logic [68:0] e;
    if (!rst_n) begin
      mq.delete();
      m_retire = 32'd0;
      m_sticky = 1'b0;
      live = 1'b1;
    end else if (live) begin
      m_push = in_ch.valid && (mq.size() < 2);
      m_pop  = (mq.size() > 0) && out_ch.ready;
      e = model_entry(in_op, in_a, in_b, in_ch.data, in_carry);
      if (m_pop) begin
        void'(mq.pop_front());
        if (m_retire != 32'hFFFF_FFFF) m_retire = m_retire + 32'd1;
      end
      if (m_push) mq.push_back(e);
      if (clr_sticky) m_sticky = 1'b0;
      if (m_push && e[4]) m_sticky = 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      chk("m_in_ready", 64'(in_ch.ready), 64'(mq.size() < 2));
      chk("m_out_valid", 64'(out_ch.valid), 64'(mq.size() > 0));
      chk("m_retire", 64'(retire_count), 64'(m_retire));
      chk("m_sticky", 64'(div0_sticky), 64'(m_sticky));
      if (mq.size() > 0) begin
        chk("m_result", out_ch.data, mq[0][68:5]);
        chk("m_flags", 64'(out_flags), 64'(mq[0][4:0]));
      end
    end
  end

  task automatic set_in(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] r, input logic cy);
    in_op = op; in_a = a; in_b = b; in_ch.data = r; in_carry = cy;
    in_ch.valid = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic wait_accept();
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ch.ready) break;
      w++;
      if (w > 50) begin
        total++; bad++;
        $display("FAIL accept_timeout in_ready stuck low at %0t", $time);
        break;
      end
    end
    @(posedge clk); #1;
    in_ch.valid = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] r, input logic cy);
    set_in(op, a, b, r, cy);
    wait_accept();
  endtask

  task automatic send_chk(input string nm, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] r, input logic cy,
                          input logic [63:0] exp_r, input logic [4:0] exp_f);
    send(op, a, b, r, cy);
    @(negedge clk);
    chk({nm, "_valid"}, 64'(out_ch.valid), 64'd1);
    chk({nm, "_result"}, out_ch.data, exp_r);
    chk({nm, "_flags"}, 64'(out_flags), 64'(exp_f));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; out_ch.ready = 1'b1; clr_sticky = 1'b0;
    set_in(4'h0, 64'd5, 64'd6, 64'd11, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ch.ready), 64'd1);
    chk("rst_out_valid", 64'(out_ch.valid), 64'd0);
    chk("rst_out_result", out_ch.data, 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_retire", 64'(retire_count), 64'd0);
    chk("rst_sticky", 64'(div0_sticky), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_ch.valid = 1'b0;
    @(posedge clk); #1;

    // Flag vectors; flags are {dz,v,c,n,z}
    send_chk("add_wrap", 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 64'd0, 5'b00101);
    send_chk("sub_borrow", 4'h1, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFF, 5'b00110);
    send_chk("sub_ovf", 4'h1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0,
             64'h7FFF_FFFF_FFFF_FFFF, 5'b01000);
    send_chk("undef_as_add", 4'h6, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000,
             1'b0, 64'h8000_0000_0000_0000, 5'b01010);
    send_chk("mul", 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFE, 5'b00010);
    send_chk("div_ok", 4'h3, 64'd10, 64'd2, 64'd5, 1'b0, 64'd5, 5'b00000);
    send_chk("and_zero", 4'h8, 64'hF0, 64'h0F, 64'd0, 1'b1, 64'd0, 5'b00001);
    send(4'h9, 64'hF0, 64'h0F, 64'hFF, 1'b0);
    send(4'hA, 64'hFF, 64'h0F, 64'hF0, 1'b0);
    send(4'hC, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(4'h7, 64'd3, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b1);

    send_chk("div0", 4'h3, 64'd10, 64'd0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 5'b10010);
    chk("div0_sticky_set", 64'(div0_sticky), 64'd1);
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_cleared", 64'(div0_sticky), 64'd0);
    @(posedge clk); #1;
    clr_sticky = 1'b1;
    send(4'h3, 64'd7, 64'd0, 64'd1, 1'b0);
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("sticky_set_wins", 64'(div0_sticky), 64'd1);
    @(posedge clk); #1;

    // Back-pressure: third push held until the consumer drains
    out_ch.ready = 1'b0;
    send(4'h0, 64'd1, 64'd1, 64'd2, 1'b0);
    send(4'h0, 64'd2, 64'd2, 64'd4, 1'b0);
    set_in(4'h0, 64'd3, 64'd3, 64'd6, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(in_ch.ready), 64'd0);
      chk("bp_head_held", out_ch.data, 64'd2);
    end
    base = int'(m_retire);
    @(posedge clk); #1;
    out_ch.ready = 1'b1;
    wait_accept();
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_retired3", 64'(retire_count), 64'(base + 3));
    chk("bp_drained", 64'(out_ch.valid), 64'd0);
    @(posedge clk); #1;

    // Simultaneous push and pop with one entry resident
    out_ch.ready = 1'b0;
    send(4'h0, 64'd100, 64'd0, 64'd100, 1'b0);
    out_ch.ready = 1'b1;
    base = int'(m_retire);
    for (int i = 0; i < 10; i++) begin
      set_in(4'h0, 64'(i), 64'(i), 64'(2 * i), 1'b0);
      @(negedge clk);
      chk("pp_out_valid", 64'(out_ch.valid), 64'd1);
      chk("pp_in_ready", 64'(in_ch.ready), 64'd1);
      @(posedge clk); #1;
    end
    in_ch.valid = 1'b0;
    @(negedge clk);
    chk("pp_retired10", 64'(retire_count), 64'(base + 10));
    chk("pp_last_head", out_ch.data, 64'd18);
    @(posedge clk); #1;

    // Reset with two entries resident drops them
    out_ch.ready = 1'b0;
    send(4'h3, 64'd1, 64'd0, 64'd0, 1'b0);
    send(4'h0, 64'd4, 64'd4, 64'd8, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_ch.valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ch.ready), 64'd1);
    chk("mid_rst_result", out_ch.data, 64'd0);
    chk("mid_rst_sticky", 64'(div0_sticky), 64'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
